// File: rtl/ex_reg_pkg.sv
// Shared ISA encodings for the execute stage: ALU ops, memory ops and exception codes.
// Also holds the helper that decides which ALU ops report a meaningful signed overflow.
package ex_reg_pkg;

  localparam int ALU_OP_W = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_OP_NOP  = 4'd0,
    ALU_OP_AND  = 4'd1,
    ALU_OP_OR   = 4'd2,
    ALU_OP_XOR  = 4'd3,
    ALU_OP_ADDS = 4'd4,
    ALU_OP_ADDU = 4'd5,
    ALU_OP_SUBS = 4'd6,
    ALU_OP_SUBU = 4'd7,
    ALU_OP_SHRL = 4'd8,
    ALU_OP_SHLL = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    MEM_OP_NOP   = 2'd0,
    MEM_OP_LOAD  = 2'd1,
    MEM_OP_STORE = 2'd2
  } mem_op_e;

  typedef enum logic [2:0] {
    EXP_NO_EXP     = 3'd0,
    EXP_EXT_INT    = 3'd1,
    EXP_UNDEF_INSN = 3'd2,
    EXP_MISS_ALIGN = 3'd3,
    EXP_OVERFLOW   = 3'd4,
    EXP_TRAP       = 3'd5,
    EXP_PRV_VIO    = 3'd6
  } exp_code_e;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  // Only the signed add/sub ops drive a defined overflow flag.
  function automatic logic is_signed_arith(input logic [ALU_OP_W-1:0] op);
    return (op == ALU_OP_ADDS) || (op == ALU_OP_SUBS);
  endfunction

endpackage

// File: rtl/ex_reg_ovf_counter.sv
// Saturating event counter with synchronous clear, hold and increment enable.
// Priority: clear > hold > increment; sticks at all-ones instead of wrapping.
module ovf_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             i_clr,
  input  logic             i_hold,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_count <= '0;
    end else if (!i_hold && i_inc && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/ex_reg.sv
// EX/MEM pipeline register: latches ALU result and side-band state, turns a qualified
// signed overflow into an exception that squashes the write-back and memory access.
module ex_reg
  import ex_reg_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 30,
  parameter int REG_ADDR_W = 5,
  parameter int MEM_OP_W   = 2,
  parameter int EXP_W      = 3,
  parameter int CNT_W      = 16
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Stall,
  input  logic                  Flush,
  input  logic [ADDR_W-1:0]     IdPC,
  input  logic                  IdEn,
  input  logic [ALU_OP_W-1:0]   IdAluOp,
  input  logic [DATA_W-1:0]     AluOut,
  input  logic                  AluOF,
  input  logic [MEM_OP_W-1:0]   IdMemOp,
  input  logic [DATA_W-1:0]     IdMemWrData,
  input  logic [REG_ADDR_W-1:0] IdDstAddr,
  input  logic                  IdGprWe,
  input  logic [EXP_W-1:0]      IdExpCode,
  output logic [ADDR_W-1:0]     ExPC,
  output logic                  ExEn,
  output logic [MEM_OP_W-1:0]   ExMemOp,
  output logic [DATA_W-1:0]     ExMemWrData,
  output logic [REG_ADDR_W-1:0] ExDstAddr,
  output logic                  ExGprWe,
  output logic [EXP_W-1:0]      ExExpCode,
  output logic [DATA_W-1:0]     ExOut,
  output logic [CNT_W-1:0]      OfCount
);

  logic w_ovf_hit;
  logic w_ovf_exp;
  logic w_normal;

  // An upstream exception is older than the overflow and masks it.
  assign w_ovf_hit = IdEn & AluOF & is_signed_arith(IdAluOp);
  assign w_ovf_exp = w_ovf_hit & (IdExpCode == EXP_NO_EXP);
  assign w_normal  = ~Stall & ~Flush;

  logic [ADDR_W-1:0]     r_pc;
  logic                  r_en;
  logic [MEM_OP_W-1:0]   r_mem_op;
  logic [DATA_W-1:0]     r_mem_wr_data;
  logic [REG_ADDR_W-1:0] r_dst_addr;
  logic                  r_gpr_we;
  logic [EXP_W-1:0]      r_exp_code;
  logic [DATA_W-1:0]     r_out;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_pc          <= '0;
      r_en          <= DISABLE;
      r_mem_op      <= MEM_OP_NOP;
      r_mem_wr_data <= '0;
      r_dst_addr    <= '0;
      r_gpr_we      <= DISABLE;
      r_exp_code    <= EXP_NO_EXP;
      r_out         <= '0;
    end else if (!Stall) begin
      // Datapath fields load even on a flush; the cleared control bits make them dead.
      r_pc          <= IdPC;
      r_mem_wr_data <= IdMemWrData;
      r_dst_addr    <= IdDstAddr;
      r_out         <= AluOut;
      if (Flush) begin
        r_en       <= DISABLE;
        r_mem_op   <= MEM_OP_NOP;
        r_gpr_we   <= DISABLE;
        r_exp_code <= EXP_NO_EXP;
      end else begin
        r_en       <= IdEn;
        r_mem_op   <= (IdEn && !w_ovf_exp) ? IdMemOp : MEM_OP_NOP;
        r_gpr_we   <= IdEn & IdGprWe & ~w_ovf_exp;
        r_exp_code <= w_ovf_exp ? EXP_OVERFLOW : IdExpCode;
      end
    end
  end

  ovf_counter #(
    .CNT_W(CNT_W)
  ) u_ovf_counter (
    .clk    (Clk),
    .i_clr  (Reset),
    .i_hold (Stall),
    .i_inc  (w_normal & w_ovf_exp),
    .o_count(OfCount)
  );

  assign ExPC        = r_pc;
  assign ExEn        = r_en;
  assign ExMemOp     = r_mem_op;
  assign ExMemWrData = r_mem_wr_data;
  assign ExDstAddr   = r_dst_addr;
  assign ExGprWe     = r_gpr_we;
  assign ExExpCode   = r_exp_code;
  assign ExOut       = r_out;

endmodule

// File: tb/tb_ex_reg.sv
// Scoreboard bench for ex_reg: stimulus pushes hand-computed expectations into a queue,
// an independent monitor pops one entry per clock and compares every output.
module tb_ex_reg;
  import ex_reg_pkg::*;

  localparam int CNT_W = 2;

  logic        Clk = 1'b0;
  logic        Reset, Stall, Flush, IdEn, AluOF, IdGprWe;
  logic [29:0] IdPC;
  logic [3:0]  IdAluOp;
  logic [31:0] AluOut, IdMemWrData;
  logic [1:0]  IdMemOp;
  logic [4:0]  IdDstAddr;
  logic [2:0]  IdExpCode;
  logic [29:0] ExPC;
  logic        ExEn, ExGprWe;
  logic [1:0]  ExMemOp;
  logic [31:0] ExMemWrData, ExOut;
  logic [4:0]  ExDstAddr;
  logic [2:0]  ExExpCode;
  logic [CNT_W-1:0] OfCount;

  always #5 Clk = ~Clk;

  ex_reg #(.CNT_W(CNT_W)) dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush),
    .IdPC(IdPC), .IdEn(IdEn), .IdAluOp(IdAluOp), .AluOut(AluOut), .AluOF(AluOF),
    .IdMemOp(IdMemOp), .IdMemWrData(IdMemWrData), .IdDstAddr(IdDstAddr),
    .IdGprWe(IdGprWe), .IdExpCode(IdExpCode),
    .ExPC(ExPC), .ExEn(ExEn), .ExMemOp(ExMemOp), .ExMemWrData(ExMemWrData),
    .ExDstAddr(ExDstAddr), .ExGprWe(ExGprWe), .ExExpCode(ExExpCode),
    .ExOut(ExOut), .OfCount(OfCount)
  );

  typedef struct packed {
    logic rst, stall, flush;
    logic [29:0] pc; logic en; logic [3:0] op; logic [31:0] alu; logic of;
    logic [1:0] mem; logic [31:0] wd; logic [4:0] dst; logic we; logic [2:0] exp;
  } in_t;

  typedef struct packed {
    logic [29:0] pc; logic en; logic [1:0] mem; logic [31:0] wd; logic [4:0] dst;
    logic we; logic [2:0] exp; logic [31:0] out; logic [CNT_W-1:0] cnt;
  } out_t;

  out_t sb_q[$];
  int   tag_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   vec     = 0;

  function automatic in_t mi(input logic rst, stall, flush, input logic [29:0] pc,
      input logic en, input logic [3:0] op, input logic [31:0] alu, input logic of,
      input logic [1:0] mem, input logic [31:0] wd, input logic [4:0] dst,
      input logic we, input logic [2:0] exp);
    return '{rst, stall, flush, pc, en, op, alu, of, mem, wd, dst, we, exp};
  endfunction

  function automatic out_t mo(input logic [29:0] pc, input logic en, input logic [1:0] mem,
      input logic [31:0] wd, input logic [4:0] dst, input logic we, input logic [2:0] exp,
      input logic [31:0] out, input logic [CNT_W-1:0] cnt);
    return '{pc, en, mem, wd, dst, we, exp, out, cnt};
  endfunction

  task automatic check(input string name, input int tag, input logic [63:0] act,
                       input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL vec%0d %s: got %0h, expected %0h", tag, name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; the expectation is for the following rising edge.
  task automatic cyc(input in_t s, input out_t e);
    @(negedge Clk);
    Reset = s.rst; Stall = s.stall; Flush = s.flush;
    IdPC = s.pc; IdEn = s.en; IdAluOp = s.op; AluOut = s.alu; AluOF = s.of;
    IdMemOp = s.mem; IdMemWrData = s.wd; IdDstAddr = s.dst; IdGprWe = s.we;
    IdExpCode = s.exp;
    sb_q.push_back(e);
    tag_q.push_back(vec);
    vec++;
  endtask

  initial begin : monitor
    out_t e;
    int   t;
    forever begin
      @(posedge Clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        t = tag_q.pop_front();
        check("ExPC",        t, 64'(ExPC),        64'(e.pc));
        check("ExEn",        t, 64'(ExEn),        64'(e.en));
        check("ExMemOp",     t, 64'(ExMemOp),     64'(e.mem));
        check("ExMemWrData", t, 64'(ExMemWrData), 64'(e.wd));
        check("ExDstAddr",   t, 64'(ExDstAddr),   64'(e.dst));
        check("ExGprWe",     t, 64'(ExGprWe),     64'(e.we));
        check("ExExpCode",   t, 64'(ExExpCode),   64'(e.exp));
        check("ExOut",       t, 64'(ExOut),       64'(e.out));
        check("OfCount",     t, 64'(OfCount),     64'(e.cnt));
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    in_t  s_a, s_b, s_c;
    out_t o_a, o_b, z;
    Reset = 1'b1; Stall = 1'b0; Flush = 1'b0; IdPC = '0; IdEn = 1'b0; IdAluOp = '0;
    AluOut = '0; AluOF = 1'b0; IdMemOp = '0; IdMemWrData = '0; IdDstAddr = '0;
    IdGprWe = 1'b0; IdExpCode = '0;
    z = mo('0, 0, MEM_OP_NOP, '0, '0, 0, EXP_NO_EXP, '0, '0);

    // Reset held two cycles with live overflow stimulus, then an idle cycle.
    repeat (2)
      cyc(mi(1, 0, 0, 30'h123, 1, ALU_OP_ADDS, 32'hFFFF_FFFF, 1, MEM_OP_STORE, 32'h55, 5'd9, 1, EXP_NO_EXP), z);
    cyc(mi(0, 0, 0, '0, 0, ALU_OP_NOP, '0, 0, MEM_OP_NOP, '0, '0, 0, EXP_NO_EXP), z);

    // ADDU ignores the overflow flag.
    cyc(mi(0, 0, 0, 30'h10, 1, ALU_OP_ADDU, 32'h5, 1, MEM_OP_NOP, '0, 5'd3, 1, EXP_NO_EXP),
        mo(30'h10, 1, MEM_OP_NOP, '0, 5'd3, 1, EXP_NO_EXP, 32'h5, 2'd0));

    // ADDS 7FFF_FFFF + 1 overflows: store and write-back squashed, result kept.
    cyc(mi(0, 0, 0, 30'h11, 1, ALU_OP_ADDS, 32'h8000_0000, 1, MEM_OP_STORE, 32'hDEAD_BEEF, 5'd4, 1, EXP_NO_EXP),
        mo(30'h11, 1, MEM_OP_NOP, 32'hDEAD_BEEF, 5'd4, 0, EXP_OVERFLOW, 32'h8000_0000, 2'd1));

    // Load A, stall three cycles with B (an overflowing SUBS) presented, then release.
    s_a = mi(0, 0, 0, 30'h20, 1, ALU_OP_ADDU, 32'hAAAA, 0, MEM_OP_LOAD, 32'h1111, 5'd7, 1, EXP_NO_EXP);
    o_a = mo(30'h20, 1, MEM_OP_LOAD, 32'h1111, 5'd7, 1, EXP_NO_EXP, 32'hAAAA, 2'd1);
    cyc(s_a, o_a);
    s_b = mi(0, 1, 0, 30'h21, 1, ALU_OP_SUBS, 32'h5555, 1, MEM_OP_STORE, 32'h2222, 5'd8, 0, EXP_NO_EXP);
    repeat (3) cyc(s_b, o_a);
    s_b.stall = 1'b0;
    o_b = mo(30'h21, 1, MEM_OP_NOP, 32'h2222, 5'd8, 0, EXP_OVERFLOW, 32'h5555, 2'd2);
    cyc(s_b, o_b);

    // Stall+Flush holds; Flush alone inserts a bubble.
    s_c = mi(0, 1, 1, 30'h30, 1, ALU_OP_ADDU, 32'h33, 0, MEM_OP_LOAD, 32'h3, 5'd9, 1, EXP_NO_EXP);
    cyc(s_c, o_b);
    s_c.stall = 1'b0;
    cyc(s_c, mo(30'h30, 0, MEM_OP_NOP, 32'h3, 5'd9, 0, EXP_NO_EXP, 32'h33, 2'd2));

    // Flushed overflow does not count; IdEn=0 forces control inactive.
    cyc(mi(0, 0, 1, 30'h31, 1, ALU_OP_SUBS, 32'h44, 1, MEM_OP_STORE, 32'h4, 5'd10, 1, EXP_NO_EXP),
        mo(30'h31, 0, MEM_OP_NOP, 32'h4, 5'd10, 0, EXP_NO_EXP, 32'h44, 2'd2));
    cyc(mi(0, 0, 0, 30'h32, 0, ALU_OP_ADDS, 32'h66, 1, MEM_OP_STORE, 32'h6, 5'd11, 1, EXP_NO_EXP),
        mo(30'h32, 0, MEM_OP_NOP, 32'h6, 5'd11, 0, EXP_NO_EXP, 32'h66, 2'd2));

    // Upstream exception wins over a simultaneous overflow.
    cyc(mi(0, 0, 0, 30'h33, 1, ALU_OP_ADDS, 32'h77, 1, MEM_OP_LOAD, 32'h7, 5'd12, 1, EXP_UNDEF_INSN),
        mo(30'h33, 1, MEM_OP_LOAD, 32'h7, 5'd12, 1, EXP_UNDEF_INSN, 32'h77, 2'd2));

    // Clear, then five SUBS overflows: the 2-bit count saturates at 3.
    cyc(mi(1, 0, 0, '0, 0, ALU_OP_NOP, '0, 0, MEM_OP_NOP, '0, '0, 0, EXP_NO_EXP), z);
    for (int i = 0; i < 5; i++)
      cyc(mi(0, 0, 0, 30'(30'h40 + i), 1, ALU_OP_SUBS, 32'(32'h8000_0000 + i), 1, MEM_OP_STORE, 32'(i), 5'd13, 1, EXP_NO_EXP),
          mo(30'(30'h40 + i), 1, MEM_OP_NOP, 32'(i), 5'd13, 0, EXP_OVERFLOW, 32'(32'h8000_0000 + i), (i < 3) ? 2'(i + 1) : 2'd3));

    // Reset during a stall still clears everything.
    cyc(mi(1, 1, 0, 30'h7, 1, ALU_OP_SUBS, 32'h8000_0000, 1, MEM_OP_STORE, 32'h9, 5'd1, 1, EXP_NO_EXP), z);

    // Overflow under an upstream exception neither replaces the code nor counts.
    for (int i = 0; i < 2; i++)
      cyc(mi(0, 0, 0, 30'(30'h50 + i), 1, ALU_OP_SUBS, 32'h8000_0000, 1, MEM_OP_STORE, 32'h9, 5'd14, 1, EXP_UNDEF_INSN),
          mo(30'(30'h50 + i), 1, MEM_OP_STORE, 32'h9, 5'd14, 1, EXP_UNDEF_INSN, 32'h8000_0000, 2'd0));
    cyc(mi(0, 0, 0, 30'h52, 1, ALU_OP_SUBS, 32'h8000_0001, 1, MEM_OP_LOAD, 32'hA, 5'd15, 1, EXP_NO_EXP),
        mo(30'h52, 1, MEM_OP_NOP, 32'hA, 5'd15, 0, EXP_OVERFLOW, 32'h8000_0001, 2'd1));

    for (int i = 0; i < 10 && sb_q.size() != 0; i++) begin
      @(posedge Clk);
      #2;
    end
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
